comma_align: RTL and testbench
==============================

// Module: comma_align
// PURPOSE
//  Receive word aligner ahead of Dec8B10B. Takes unaligned 10-bit words from the deserializer (bit 9 = first bit on the wire, 'a').
//  Finds K28.x commas (abcdeif = 0011111 / 1100000) at any of 10 bit offsets and locks onto one offset.
//  Presents 10-bit symbols aligned on the decoder's in[9:0] boundary.
//  Drops lock on repeated code errors, fed back from the decoder's code_err.
// PARAMETERS
//  LOCK_COMMAS  3   consecutive commas at the same offset needed to assert locked (1..15)
//  LOSS_ERRS    4   errors accumulated while locked that force loss of sync (1..15)
//  GOOD_CLR     16  consecutive error-free cycles that clear the error count (1..255)
// PORTS
//  BYTECLK    in   1   symbol clock, all logic on rising edge
//  reset      in   1   synchronous, active-high
//  in_raw     in   10  unaligned word, bit 9 earliest
//  err_in     in   1   code_err from downstream decoder, 1 = bad symbol
//  out        out  10  aligned symbol, bit 9 = 'a'; feeds Dec8B10B in
//  comma_out  out  1   out[9:3] is a comma pattern
//  locked     out  1   alignment acquired and held
//  align_off  out  4   bit offset in use (0..9)
//  slip       out  1   one-cycle pulse when align_off changes
// BEHAVIOUR
//  Reset: r0,r1,out=0; comma_out,locked,slip=0; align_off=0; FSM=UNSYNC; all counters=0. Reset wins over every other event.
//  Pipeline: r0<=in_raw, r1<=r0; window w[19:0]={r1,r0}.
//    Candidate word at offset k = w[19-k -: 10]; comma at k when w[19-k -: 7] = 0011111 or 1100000.
//  Multiple comma hits in one window: lowest k wins. Commas are searched every cycle in every state.
//  out <= w[19-align_off -: 10] (uses align_off before this edge's update).
//    comma_out registered alongside out. Latency: at offset 0, out at edge N+2 = in_raw sampled at edge N.
//  FSM, updated on the same edge that registers out:
//   UNSYNC: comma at k -> align_off<=k (slip if changed), cnt<=1, go ACQ.
//     If LOCK_COMMAS==1, go straight to LOCKED.
//   ACQ: comma at align_off -> cnt++; cnt reaching LOCK_COMMAS -> LOCKED, locked<=1.
//     Comma at other k -> align_off<=k, slip, cnt<=1.
//     No comma -> hold cnt.
//   LOCKED: align_off frozen.
//     Error event = err_in=1 OR comma at k!=align_off (both in one cycle = one event).
//     Event -> errcnt++ and goodcnt<=0. No event -> goodcnt++; goodcnt reaching GOOD_CLR -> errcnt<=0, goodcnt<=0.
//     errcnt reaching LOSS_ERRS -> UNSYNC, locked<=0, errcnt/goodcnt/cnt<=0; align_off kept until next comma.
//  err_in is ignored outside LOCKED (decoder errors during acquisition are expected).
//  Counters never wrap: cnt stops at LOCK_COMMAS; goodcnt, errcnt cleared at threshold.
//  slip is high only on the cycle after align_off changes; never high on reset exit.
// CONFIGURATION
//  ALIGN_STATS_EN defined: adds output realign_cnt[15:0].
//    Increments on every LOCKED->UNSYNC transition, saturates at 16'hFFFF, 0 on reset.
//  ALIGN_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 in_raw = K28.5- 0011111010 every cycle -> comma_out=1, align_off=0, slip never pulses.
//    locked=1 on the cycle out shows the 3rd comma; out = 0011111010.
//  2 Same stream rotated 3 bits late (bits split across words) -> align_off=3, one slip pulse.
//    out = 0011111010 each cycle; locked after 3 commas.
//  3 Locked, D21.5 1010101010 traffic; err_in=1 on 4 cycles within 16 -> locked=0 on the cycle after the 4th.
//    FSM=UNSYNC; realign_cnt=1 with ALIGN_STATS_EN.
//  4 Locked; err_in on 3 cycles, then 16 clean cycles, then 3 more errors -> locked stays 1 throughout.
//  5 Locked at offset 0; one K28.5+ 1100000101 inserted at offset 5 -> align_off stays 0.
//    Counts as one error; locked stays 1.
//  6 ACQ with cnt=2, reset pulsed for 1 cycle -> all outputs 0.
//    3 fresh commas are needed before locked=1.

Source files
------------

// File: rtl/comma_align.sv
// rtl/comma_align.sv - 8b/10b receive comma aligner with lock/loss-of-sync FSM
//
// Purpose: takes unaligned 10-bit words from the deserializer, searches all
//   ten bit offsets for K28.x commas, locks onto one offset and presents
//   aligned symbols to the 8b/10b decoder. Lock is dropped after repeated
//   decoder code errors or stray commas.
//
// Optional feature macro: ALIGN_STATS_EN (adds realign_cnt output).
//
// Ports:
//   BYTECLK     in   symbol clock, rising edge
//   reset       in   synchronous, active-high
//   in_raw      in   [9:0] unaligned word, bit 9 earliest on the wire
//   err_in      in   code error from the downstream decoder
//   out         out  [9:0] aligned symbol, bit 9 = 'a'
//   comma_out   out  out[9:3] holds a comma pattern
//   locked      out  alignment acquired and held
//   align_off   out  [3:0] bit offset in use (0..9)
//   slip        out  one-cycle pulse after align_off changes
//   realign_cnt out  [15:0] saturating LOCKED->UNSYNC count (ALIGN_STATS_EN)

module comma_align #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_ERRS   = 4,
  parameter int GOOD_CLR    = 16
) (
  input  logic        BYTECLK,
  input  logic        reset,
  input  logic [9:0]  in_raw,
  input  logic        err_in,
  output logic [9:0]  out,
  output logic        comma_out,
  output logic        locked,
  output logic [3:0]  align_off,
  output logic        slip
`ifdef ALIGN_STATS_EN
  ,
  output logic [15:0] realign_cnt
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);
  localparam logic [7:0] GOOD_N = 8'(GOOD_CLR);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [9:0]  r0, r1;
  logic [19:0] win;
  logic [9:0]  hit;
  logic [15:0] hit_ext;
  logic        hit_any;
  logic [3:0]  hit_k;
  logic        hit_at_off;
  logic [9:0]  out_nxt;
  logic        err_event;

  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic [3:0]  errcnt, errcnt_nxt, errcnt_inc;
  logic [7:0]  goodcnt, goodcnt_nxt, goodcnt_inc;
  logic [3:0]  align_off_nxt;
  logic        locked_nxt;

  // Two-word window; earlier word in the upper half.
  assign win = {r1, r0};

  // Comma search at every offset, every cycle, in every state.
  always_comb begin
    hit = '0;
    for (int k = 0; k < 10; k++) begin
      hit[k] = (win[19-k -: 7] == 7'b0011111) || (win[19-k -: 7] == 7'b1100000);
    end
  end

  // Lowest offset wins when several offsets show a comma: scan downwards so
  // the last assignment is the smallest k.
  always_comb begin
    hit_any = 1'b0;
    hit_k   = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        hit_k   = 4'(k);
      end
    end
  end

  // comma_out for the symbol being registered is simply the hit at the
  // offset currently in use.
  assign hit_ext    = {6'd0, hit};
  assign hit_at_off = hit_ext[align_off];
  assign out_nxt    = win[5'd19 - {1'b0, align_off} -: 10];

  // A decoder error and a misplaced comma in the same cycle are one event.
  assign err_event = err_in || (hit_any && (hit_k != align_off));

  assign cnt_inc     = cnt + 4'd1;
  assign errcnt_inc  = errcnt + 4'd1;
  assign goodcnt_inc = goodcnt + 8'd1;

  always_ff @(posedge BYTECLK) begin
    if (reset) begin
      state <= UNSYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    align_off_nxt = align_off;
    cnt_nxt       = cnt;
    errcnt_nxt    = errcnt;
    goodcnt_nxt   = goodcnt;
    locked_nxt    = locked;
    case (state)
      UNSYNC: begin
        if (hit_any) begin
          align_off_nxt = hit_k;
          cnt_nxt       = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_nxt  = LOCKED;
            locked_nxt = 1'b1;
          end else begin
            state_nxt = ACQ;
          end
        end
      end
      ACQ: begin
        if (hit_any) begin
          if (hit_k == align_off) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == LOCK_N) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            align_off_nxt = hit_k;
            cnt_nxt       = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (err_event) begin
          goodcnt_nxt = 8'd0;
          if (errcnt_inc == LOSS_N) begin
            // Offset is kept; the next comma in UNSYNC picks a new one.
            state_nxt  = UNSYNC;
            locked_nxt = 1'b0;
            errcnt_nxt = 4'd0;
            cnt_nxt    = 4'd0;
          end else begin
            errcnt_nxt = errcnt_inc;
          end
        end else if (goodcnt_inc == GOOD_N) begin
          errcnt_nxt  = 4'd0;
          goodcnt_nxt = 8'd0;
        end else begin
          goodcnt_nxt = goodcnt_inc;
        end
      end
      default: begin
        state_nxt  = UNSYNC;
        locked_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge BYTECLK) begin
    if (reset) begin
      r0        <= 10'd0;
      r1        <= 10'd0;
      out       <= 10'd0;
      comma_out <= 1'b0;
      locked    <= 1'b0;
      align_off <= 4'd0;
      slip      <= 1'b0;
      cnt       <= 4'd0;
      errcnt    <= 4'd0;
      goodcnt   <= 8'd0;
    end else begin
      r0        <= in_raw;
      r1        <= r0;
      out       <= out_nxt;
      comma_out <= hit_at_off;
      locked    <= locked_nxt;
      align_off <= align_off_nxt;
      slip      <= (align_off_nxt != align_off);
      cnt       <= cnt_nxt;
      errcnt    <= errcnt_nxt;
      goodcnt   <= goodcnt_nxt;
    end
  end

`ifdef ALIGN_STATS_EN
  logic lose_sync;
  assign lose_sync = (state == LOCKED) && (state_nxt == UNSYNC);

  always_ff @(posedge BYTECLK) begin
    if (reset) begin
      realign_cnt <= 16'd0;
    end else if (lose_sync && (realign_cnt != 16'hFFFF)) begin
      realign_cnt <= realign_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comma_align.sv
// tb/tb_comma_align.sv - testbench for comma_align
module tb_comma_align;

  localparam int LOCK_COMMAS = 3;
  localparam int LOSS_ERRS   = 4;
  localparam int GOOD_CLR    = 16;

  localparam logic [9:0] KM = 10'b0011111010; // K28.5-
  localparam logic [9:0] KP = 10'b1100000101; // K28.5+
  localparam logic [9:0] DD = 10'b1010101010; // D21.5
  localparam logic [9:0] W3 = 10'b0100011111; // K28.5- stream, 3 bits late
  localparam logic [9:0] KA = 10'b1010111000; // D21.5 head + K28.5+ head (offset 5)
  localparam logic [9:0] KB = 10'b0010101010; // K28.5+ tail + D21.5 tail

  logic        BYTECLK = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  in_raw = 10'd0;
  logic        err_in = 1'b0;
  logic [9:0]  out;
  logic        comma_out;
  logic        locked;
  logic [3:0]  align_off;
  logic        slip;
`ifdef ALIGN_STATS_EN
  logic [15:0] realign_cnt;
`endif

  comma_align #(
    .LOCK_COMMAS(LOCK_COMMAS),
    .LOSS_ERRS  (LOSS_ERRS),
    .GOOD_CLR   (GOOD_CLR)
  ) dut (
    .BYTECLK    (BYTECLK),
    .reset      (reset),
    .in_raw     (in_raw),
    .err_in     (err_in),
    .out        (out),
    .comma_out  (comma_out),
    .locked     (locked),
    .align_off  (align_off),
    .slip       (slip)
`ifdef ALIGN_STATS_EN
    ,
    .realign_cnt(realign_cnt)
`endif
  );

  always #5 BYTECLK = ~BYTECLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bit-stream history plus an abstract sync state.
  logic [19:0] m_w;
  int          m_mode;     // 0 hunting, 1 acquiring, 2 in sync
  int          m_off, m_cnt, m_errs, m_good, m_realign;
  logic [9:0]  m_out;
  logic        m_comma, m_locked, m_slip;

  function automatic logic is_comma(input logic [6:0] c);
    return (c == 7'b0011111) || (c == 7'b1100000);
  endfunction

  function automatic int first_comma(input logic [19:0] w);
    logic [19:0] t;
    for (int k = 0; k < 10; k++) begin
      t = w >> (13 - k);
      if (is_comma(t[6:0])) return k;
    end
    return -1;
  endfunction

  function automatic logic [9:0] rotr(input logic [9:0] x, input int r);
    logic [19:0] t;
    t = {x, x} >> r;
    return t[9:0];
  endfunction

  task automatic model_edge(input logic [9:0] d, input logic e, input logic r);
    int k, new_off;
    logic [19:0] t;
    if (r) begin
      m_w = '0; m_mode = 0; m_off = 0; m_cnt = 0; m_errs = 0; m_good = 0;
      m_realign = 0; m_out = '0; m_comma = 0; m_locked = 0; m_slip = 0;
      return;
    end
    k = first_comma(m_w);
    t = m_w >> (10 - m_off);
    m_out = t[9:0];
    m_comma = is_comma(m_out[9:3]);
    new_off = m_off;
    if (m_mode == 0) begin
      if (k >= 0) begin
        new_off = k; m_cnt = 1;
        if (LOCK_COMMAS == 1) begin m_mode = 2; m_locked = 1; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (k == m_off) begin
        m_cnt++;
        if (m_cnt >= LOCK_COMMAS) begin m_mode = 2; m_locked = 1; end
      end else if (k >= 0) begin
        new_off = k; m_cnt = 1;
      end
    end else begin
      if (e || (k >= 0 && k != m_off)) begin
        m_errs++; m_good = 0;
        if (m_errs >= LOSS_ERRS) begin
          m_mode = 0; m_locked = 0; m_errs = 0; m_cnt = 0;
          if (m_realign < 65535) m_realign++;
        end
      end else begin
        m_good++;
        if (m_good >= GOOD_CLR) begin m_errs = 0; m_good = 0; end
      end
    end
    m_slip = (new_off != m_off);
    m_off = new_off;
    m_w = {m_w[9:0], d};
  endtask

  task automatic check_model(input string tag);
    logic [16:0] act, exp;
    act = {out, comma_out, locked, align_off, slip};
    exp = {m_out, m_comma, m_locked, 4'(m_off), m_slip};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got out=%b comma=%b locked=%b off=%0d slip=%b, want out=%b comma=%b locked=%b off=%0d slip=%b",
               tag, $time, act[16:7], act[6], act[5], act[4:1], act[0],
               exp[16:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
`ifdef ALIGN_STATS_EN
    n_cmp++;
    if (realign_cnt !== 16'(m_realign)) begin
      n_bad++;
      $display("FAIL %s realign_cnt: got %0d want %0d", tag, realign_cnt, m_realign);
    end
`endif
  endtask

  task automatic expect_val(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] d, input logic e, input logic r, input string tag);
    in_raw = d; err_in = e; reset = r;
    model_edge(d, e, r);
    @(posedge BYTECLK);
    #1;
    check_model(tag);
  endtask

  task automatic lock_up();
    step(KM, 1'b0, 1'b1, "lock_rst");
    repeat (6) step(KM, 1'b0, 1'b0, "lock_k");
    expect_val("lock_up locked", int'(locked), 1);
  endtask

  typedef struct {
    logic       rst;
    logic [9:0] din;
    logic       err;
    logic [9:0] e_out;
    logic       e_comma;
    logic       e_locked;
    logic [3:0] e_off;
    logic       e_slip;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input logic r, input logic [9:0] d, input logic e,
                               input logic [9:0] o, input logic c, input logic l,
                               input logic [3:0] off, input logic s);
    vec_t v;
    v.rst = r; v.din = d; v.err = e; v.e_out = o; v.e_comma = c;
    v.e_locked = l; v.e_off = off; v.e_slip = s;
    return v;
  endfunction

  initial begin
    logic [16:0] act, exp;
    logic [9:0]  d;
    int          rot, p;

    // Aligned K28.5- stream: locked when out shows the 3rd comma.
    vt.push_back(mkv(1, KM, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, KM,    1, 0, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, KM,    1, 0, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, KM,    1, 1, 4'd0, 0));
    vt.push_back(mkv(0, KM, 0, KM,    1, 1, 4'd0, 0));
    // Same stream 3 bits late: one slip to offset 3, then aligned commas.
    vt.push_back(mkv(1, W3, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, W3, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, W3, 0, 10'd0, 0, 0, 4'd0, 0));
    vt.push_back(mkv(0, W3, 0, W3,    0, 0, 4'd3, 1));
    vt.push_back(mkv(0, W3, 0, KM,    1, 0, 4'd3, 0));
    vt.push_back(mkv(0, W3, 0, KM,    1, 1, 4'd3, 0));
    vt.push_back(mkv(0, W3, 0, KM,    1, 1, 4'd3, 0));

    for (int i = 0; i < vt.size(); i++) begin
      in_raw = vt[i].din; err_in = vt[i].err; reset = vt[i].rst;
      model_edge(vt[i].din, vt[i].err, vt[i].rst);
      @(posedge BYTECLK);
      #1;
      act = {out, comma_out, locked, align_off, slip};
      exp = {vt[i].e_out, vt[i].e_comma, vt[i].e_locked, vt[i].e_off, vt[i].e_slip};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got out=%b comma=%b locked=%b off=%0d slip=%b, want out=%b comma=%b locked=%b off=%0d slip=%b",
                 i, act[16:7], act[6], act[5], act[4:1], act[0],
                 exp[16:7], exp[6], exp[5], exp[4:1], exp[0]);
      end
    end

    // Four errors within 16 cycles lose sync on the cycle after the 4th.
    lock_up();
    step(DD, 0, 0, "t3"); step(DD, 0, 0, "t3");
    step(DD, 1, 0, "t3"); step(DD, 0, 0, "t3");
    step(DD, 1, 0, "t3"); step(DD, 1, 0, "t3");
    expect_val("t3 locked after 3 errs", int'(locked), 1);
    step(DD, 1, 0, "t3");
    expect_val("t3 locked after 4th err", int'(locked), 0);
`ifdef ALIGN_STATS_EN
    expect_val("t3 realign_cnt", int'(realign_cnt), 1);
`endif

    // 3 errors, 16 clean cycles clear the count, 3 more errors keep lock.
    lock_up();
    repeat (3) step(DD, 1, 0, "t4");
    repeat (16) step(DD, 0, 0, "t4");
    repeat (3) begin
      step(DD, 1, 0, "t4");
      expect_val("t4 locked", int'(locked), 1);
    end

    // Stray K28.5+ at offset 5 together with err_in counts as one error.
    lock_up();
    step(DD, 0, 0, "t5"); step(DD, 0, 0, "t5");
    step(DD, 1, 0, "t5"); step(DD, 1, 0, "t5");
    step(KA, 0, 0, "t5"); step(KB, 0, 0, "t5");
    step(DD, 1, 0, "t5");
    expect_val("t5 locked after stray comma", int'(locked), 1);
    expect_val("t5 align_off", int'(align_off), 0);
    step(DD, 0, 0, "t5");
    step(DD, 1, 0, "t5");
    expect_val("t5 locked after next err", int'(locked), 0);

    // Reset in ACQ with cnt=2 clears everything; 3 fresh commas needed.
    step(KM, 0, 1, "t6");
    repeat (4) step(KM, 0, 0, "t6");
    step(KM, 0, 1, "t6 rst");
    expect_val("t6 outputs after reset",
               int'({out, comma_out, locked, align_off, slip}), 0);
    for (int i = 1; i <= 5; i++) begin
      step(KM, 0, 0, "t6");
      expect_val($sformatf("t6 locked step %0d", i), int'(locked), (i == 5) ? 1 : 0);
    end

    // Randomized segments of rotated comma/data streams with errors and resets.
    rot = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 40 == 0) rot = $urandom_range(0, 9);
      p = $urandom_range(0, 99);
      if (p < 55)      d = rotr(KM, rot);
      else if (p < 75) d = rotr(DD, rot);
      else if (p < 80) d = rotr(KP, rot);
      else             d = 10'($urandom);
      step(d, ($urandom_range(0, 99) < 8), ($urandom_range(0, 299) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
